// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared constants, FSM states and FIFO entry type for the fetch stage
package ifetch_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] EBREAK_INSTR = 32'h0010_0073;
    localparam logic [6:0]         OPC_JAL      = 7'b1101111;

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - imem, redirect and decode-side handshake bundle of the fetch stage
interface ifetch_if #(
    parameter int XLEN = ifetch_pkg::XLEN
);

    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            halted;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  halted
    );

endinterface

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - DEPTH-entry synchronous FIFO of fetch entries; flush beats push/pop
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    assign head = mem[rd_ptr];

    // Storage is only cleared on reset; a flush just rewinds the pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - PC, RUN/HALT FSM and fetch FIFO; IFETCH_BPRED_EN enables static JAL prediction
module ifetch_stage #(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);

    import ifetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_step;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            have_head;
    logic            pop;
    logic            fetch;

`ifdef IFETCH_BPRED_EN
    logic [XLEN-1:0] jal_off;

    assign jal_off = {{(XLEN-21){bus.imem_rdata[31]}}, bus.imem_rdata[31],
                      bus.imem_rdata[19:12], bus.imem_rdata[20],
                      bus.imem_rdata[30:21], 1'b0};
    assign pc_step = (bus.imem_rdata[6:0] == OPC_JAL) ? jal_off : XLEN'(4);
`else
    assign pc_step = XLEN'(4);
`endif

    assign have_head  = (count != '0);
    assign pop        = have_head & bus.out_ready;
    assign push_entry = '{pc: pc_q, instr: bus.imem_rdata};

    // Redirect outranks fetch; a full FIFO still fetches when its head leaves this cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fetch   = 1'b0;
        if (bus.redirect_valid) begin
            state_d = RUN;
            pc_d    = bus.redirect_pc & ~XLEN'(3);
        end else if ((state_q == RUN) && ((count < CW'(DEPTH)) || pop)) begin
            fetch = 1'b1;
            pc_d  = pc_q + pc_step;
            if (bus.imem_rdata == EBREAK_INSTR) begin
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fetch),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (bus.redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = have_head;
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;
    assign bus.halted    = (state_q == HALT);

endmodule
